// File: rtl/led_sequence_ctrl_if.sv
// Host-side table/control bus and status/LED outputs of the LED sequencer.
interface led_sequence_ctrl_if #(
  parameter int PWM_BITS = 8,
  parameter int DUR_BITS = 10
);
  logic                         cfg_we;
  logic [3:0]                   cfg_addr;
  logic [3*PWM_BITS+DUR_BITS-1:0] cfg_data;
  logic [4:0]                   num_steps;
  logic                         loop_en;
  logic                         start;
  logic                         stop;
  logic                         busy;
  logic [3:0]                   step_idx;
  logic                         done;
  logic                         LED0;
  logic                         LED1;
  logic                         LED2;

  modport master (
    output cfg_we, cfg_addr, cfg_data, num_steps, loop_en, start, stop,
    input  busy, step_idx, done, LED0, LED1, LED2
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_data, num_steps, loop_en, start, stop,
    output busy, step_idx, done, LED0, LED1, LED2
  );
endinterface

// File: rtl/led_sequence_ctrl.sv
// Plays a table of {dur, duty2, duty1, duty0} steps onto three PWM LEDs,
// each step held for dur timebase ticks (dur=0 behaves as 1).
module led_sequence_ctrl #(
  parameter int CLK_DIV   = 48000,
  parameter int NUM_STEPS = 8,
  parameter int PWM_BITS  = 8,
  parameter int DUR_BITS  = 10
) (
  input logic clk,
  input logic rst_n,
  led_sequence_ctrl_if.slave bus
);
  localparam int W  = 3*PWM_BITS + DUR_BITS;
  localparam int AW = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
  localparam int PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PMAX = PW'(CLK_DIV - 1);
  localparam logic [4:0]    NS5  = 5'(NUM_STEPS);

  typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;

  state_t                     state;
  logic [W-1:0]               tbl [NUM_STEPS];
  logic [2:0][PWM_BITS-1:0]   duty;
  logic [PWM_BITS-1:0]        pwm_cnt;
  logic [PW-1:0]              presc;
  logic [DUR_BITS-1:0]        dur_cnt;
  logic [3:0]                 step;
  logic [4:0]                 len;
  logic [2:0]                 led;
  logic                       busy_q;
  logic                       done_q;

  logic                tick;
  logic                addr_ok;
  logic                len_ok;
  logic [W-1:0]        ent;
  logic [DUR_BITS-1:0] ent_dur;
  logic                last_step;

  assign tick      = (presc == PMAX);
  assign addr_ok   = ({1'b0, bus.cfg_addr} < NS5);
  assign len_ok    = (bus.num_steps != 5'd0) && (bus.num_steps <= NS5);
  assign ent       = tbl[step[AW-1:0]];
  assign ent_dur   = ent[W-1 -: DUR_BITS];
  assign last_step = ({1'b0, step} == len - 5'd1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      for (int i = 0; i < NUM_STEPS; i++) tbl[i] <= '0;
      duty    <= '0;
      pwm_cnt <= '0;
      presc   <= '0;
      dur_cnt <= '0;
      step    <= '0;
      len     <= '0;
      led     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      for (int i = 0; i < 3; i++) led[i] <= (pwm_cnt < duty[i]);
      presc   <= tick ? '0 : presc + 1'b1;
      done_q  <= 1'b0;
      if (bus.cfg_we && addr_ok) tbl[bus.cfg_addr[AW-1:0]] <= bus.cfg_data;

      if (bus.stop) begin
        state  <= IDLE;
        busy_q <= 1'b0;
        duty   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start && len_ok) begin
              len    <= bus.num_steps;
              step   <= '0;
              presc  <= '0;
              busy_q <= 1'b1;
              state  <= LOAD;
            end
          end
          LOAD: begin
            for (int i = 0; i < 3; i++) duty[i] <= ent[i*PWM_BITS +: PWM_BITS];
            dur_cnt <= (ent_dur == '0) ? DUR_BITS'(1) : ent_dur;
            // Restart the timebase so the step spans exactly dur*CLK_DIV HOLD cycles.
            presc   <= '0;
            state   <= HOLD;
          end
          HOLD: begin
            if (tick) begin
              if (dur_cnt != DUR_BITS'(1)) begin
                dur_cnt <= dur_cnt - 1'b1;
              end else if (!last_step) begin
                step  <= step + 4'd1;
                state <= LOAD;
              end else if (bus.loop_en) begin
                step  <= '0;
                state <= LOAD;
              end else begin
                state  <= IDLE;
                busy_q <= 1'b0;
                done_q <= 1'b1;
                duty   <= '0;
              end
            end
          end
          default: begin
            state  <= IDLE;
            busy_q <= 1'b0;
            duty   <= '0;
          end
        endcase
      end
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.step_idx = step;
  assign bus.LED0     = led[0];
  assign bus.LED1     = led[1];
  assign bus.LED2     = led[2];
endmodule

// File: tb/tb_led_sequence_ctrl.sv
// Directed bench for led_sequence_ctrl with a short timebase (CLK_DIV=4).
module tb_led_sequence_ctrl;
  localparam int CLK_DIV   = 4;
  localparam int NUM_STEPS = 8;
  localparam int PWM_BITS  = 8;
  localparam int DUR_BITS  = 10;
  localparam int W         = 3*PWM_BITS + DUR_BITS;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  led_sequence_ctrl_if #(.PWM_BITS(PWM_BITS), .DUR_BITS(DUR_BITS)) ifc ();

  led_sequence_ctrl #(
    .CLK_DIV(CLK_DIV), .NUM_STEPS(NUM_STEPS), .PWM_BITS(PWM_BITS), .DUR_BITS(DUR_BITS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(ifc)
  );

  int total = 0;
  int bad   = 0;
  int ncyc, nbusy, ndone, nl0, nl1, nl2, t_chg, t_done;
  logic busy_at_done;
  logic [3:0] last_idx;
  int idx_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] ent(input int dur, input int d2, input int d1, input int d0);
    return {DUR_BITS'(dur), PWM_BITS'(d2), PWM_BITS'(d1), PWM_BITS'(d0)};
  endfunction

  task automatic clr();
    ncyc = 0; nbusy = 0; ndone = 0; nl0 = 0; nl1 = 0; nl2 = 0;
    t_chg = 0; t_done = 0; busy_at_done = 1'b1;
    idx_q.delete();
    last_idx = ifc.step_idx;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
    ncyc++;
    if (ifc.busy) nbusy++;
    if (ifc.done) begin ndone++; t_done = ncyc; busy_at_done = ifc.busy; end
    if (ifc.LED0) nl0++;
    if (ifc.LED1) nl1++;
    if (ifc.LED2) nl2++;
    if (ifc.step_idx != last_idx) begin
      idx_q.push_back(int'(ifc.step_idx));
      t_chg = ncyc;
      last_idx = ifc.step_idx;
    end
  endtask

  task automatic wr(input int addr, input logic [W-1:0] data);
    ifc.cfg_we = 1'b1; ifc.cfg_addr = 4'(addr); ifc.cfg_data = data;
    cyc();
    ifc.cfg_we = 1'b0;
  endtask

  // Start pulse; the sample right after the start edge is ncyc=1.
  task automatic go(input int n, input logic lp);
    clr();
    ifc.num_steps = 5'(n); ifc.loop_en = lp; ifc.start = 1'b1;
    cyc();
    ifc.start = 1'b0;
    idx_q.delete();
    last_idx = ifc.step_idx;
    t_chg = ncyc;
  endtask

  task automatic run_idle(input string tag, input int max);
    for (int i = 0; i < max; i++) begin
      cyc();
      if (!ifc.busy) break;
    end
    chk(tag, ifc.busy, 0);
  endtask

  initial begin
    int v;
    ifc.cfg_we = 0; ifc.cfg_addr = 0; ifc.cfg_data = '0; ifc.num_steps = 0;
    ifc.loop_en = 0; ifc.start = 0; ifc.stop = 0;
    clr();
    repeat (3) cyc();
    chk("rst_busy", ifc.busy, 0);
    chk("rst_done", ifc.done, 0);
    chk("rst_idx",  ifc.step_idx, 0);
    chk("rst_led",  {ifc.LED2, ifc.LED1, ifc.LED0}, 0);
    rst_n = 1'b1;

    // single pass: 9-cycle step0, 13-cycle step1 (LOAD + dur*4)
    wr(0, ent(2, 0, 0, 255));
    wr(1, ent(3, 0, 128, 0));
    go(2, 1'b0);
    chk("b_busy", ifc.busy, 1);
    run_idle("b_to", 100);
    chk("b_s0", t_chg, 10);
    chk("b_s1", t_done - t_chg, 13);
    chk("b_done", ndone, 1);
    chk("b_busydn", busy_at_done, 0);
    chk("b_nbusy", nbusy, 22);
    chk("b_l0", (nl0 >= 8 && nl0 <= 9), 1);
    chk("b_l2", nl2, 0);
    chk("b_idx", ifc.step_idx, 1);

    // loop, then drop loop_en during the second step1
    go(2, 1'b1);
    repeat (39) cyc();
    v = (idx_q.size() == 3) ? idx_q[0]*100 + idx_q[1]*10 + idx_q[2] : 999;
    chk("lp_seq", v, 101);
    chk("lp_nodn", ndone, 0);
    ifc.loop_en = 1'b0;
    run_idle("lp_to", 100);
    chk("lp_tdn", t_done, 45);
    chk("lp_done", ndone, 1);

    // start+stop collision in HOLD, then illegal lengths
    go(2, 1'b1);
    repeat (4) cyc();
    ifc.start = 1'b1; ifc.stop = 1'b1;
    cyc();
    ifc.start = 1'b0; ifc.stop = 1'b0;
    chk("col_busy", ifc.busy, 0);
    cyc();
    chk("col_led", {ifc.LED2, ifc.LED1, ifc.LED0}, 0);
    go(0, 1'b0);
    chk("ns0_busy", ifc.busy, 0);
    go(9, 1'b0);
    cyc();
    chk("ns9_busy", ifc.busy, 0);
    chk("col_nodn", ndone, 0);

    // rewrite step1 while it is being held
    go(2, 1'b1);
    repeat (11) cyc();
    wr(1, ent(1, 255, 0, 0));
    repeat (10) cyc();
    chk("hz_chg", t_chg, 23);
    chk("hz_idx", ifc.step_idx, 0);
    chk("hz_l2a", nl2, 0);
    nl2 = 0;
    repeat (17) cyc();
    chk("hz_s1", t_chg, 37);
    chk("hz_l2b", (nl2 >= 4 && nl2 <= 5), 1);
    ifc.stop = 1'b1;
    cyc();
    ifc.stop = 1'b0;
    chk("hz_stop", ifc.busy, 0);

    // reset mid-HOLD
    go(2, 1'b1);
    repeat (4) cyc();
    rst_n = 1'b0;
    cyc();
    chk("rm_busy", ifc.busy, 0);
    chk("rm_idx",  ifc.step_idx, 0);
    chk("rm_led",  {ifc.LED2, ifc.LED1, ifc.LED0}, 0);
    rst_n = 1'b1;

    // cleared table: dur=0 holds one tick, all dark
    go(1, 1'b0);
    chk("z_busy", ifc.busy, 1);
    run_idle("z_to", 50);
    chk("z_nbusy", nbusy, 5);
    chk("z_done", ndone, 1);
    chk("z_led", nl0 + nl1 + nl2, 0);

    // out-of-range address must not alias into the table
    wr(12, ent(5, 255, 255, 255));
    go(5, 1'b0);
    run_idle("a_to", 100);
    chk("a_nbusy", nbusy, 25);
    chk("a_led", nl0 + nl1 + nl2, 0);

    // long step: LEDs integrate over exactly two PWM periods
    wr(0, ent(128, 0, 128, 255));
    go(1, 1'b0);
    run_idle("p_to", 700);
    chk("p_nbusy", nbusy, 513);
    chk("p_l0", nl0, 510);
    chk("p_l1", nl1, 256);
    chk("p_l2", nl2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
